// File: rtl/test_data_framer_pkg.sv
// Shared types and constants for the test-data framer.
package test_data_framer_pkg;

  // Beat type of the word currently presented on DOUT
  localparam logic [1:0] BEAT_HEADER  = 2'd0;
  localparam logic [1:0] BEAT_PAYLOAD = 2'd1;
  localparam logic [1:0] BEAT_TRAILER = 2'd2;

  // Header marker placed in the upper half of the header word
  localparam logic [15:0] DEFAULT_MAGIC = 16'hCE9C;

  // The state encodes the beat held in the output register, so the
  // active states reuse the beat-type codes.
  typedef enum logic [1:0] {
    HEADER  = BEAT_HEADER,
    PAYLOAD = BEAT_PAYLOAD,
    TRAILER = BEAT_TRAILER,
    IDLE    = 2'd3
  } state_t;

endpackage

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO with a lookahead read port and a sticky
// drop flag. The writer has no back-pressure: a word arriving while
// full (with no pop on the same edge) is discarded and flagged.
module fwft_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
  logic [AW:0]      count_q;
  logic             full, empty, push, pop;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  // A pop frees a slot on the same edge, so a full FIFO still accepts
  assign push       = wr_en && (!full || rd_en);
  assign pop        = rd_en && !empty;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  assign head       = mem[rd_ptr];
  assign head_next  = mem[rd_ptr_inc];
  assign occupancy  = count_q;

  // Storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the sticky drop flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (wr_en && full && !rd_en) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/test_data_framer.sv
// Buffers the test-pattern word stream and emits framed packets:
// {MAGIC, seq} header, PKT_WORDS payload words, XOR-checksum trailer.
// The output register holds the beat being offered; payload words are
// popped from the FIFO when their beat is accepted, and the lookahead
// port supplies the following word so there is no read bubble.
module test_data_framer
  import test_data_framer_pkg::*;
#(
  parameter int          PKT_WORDS  = 16,
  parameter int          FIFO_DEPTH = 32,
  parameter logic [15:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] DIN,
  input  logic        DIN_WR_EN,
  output logic [31:0] DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        DOUT_LAST,
  output logic        OVERFLOW,
  output logic [15:0] PKT_CNT
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(PKT_WORDS + 1);
  localparam logic [OW-1:0] PKT_OCC  = OW'(PKT_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_WORDS - 1);

  state_t        state_q, state_nxt;
  logic [31:0]   dout_q, dout_nxt;
  logic          valid_q, valid_nxt;
  logic          last_q, last_nxt;
  logic [31:0]   chk_q, chk_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [15:0]   seq_q, seq_nxt;
  logic [15:0]   pkt_cnt_q, pkt_cnt_nxt;
  logic          pop, xfer;

  logic [31:0]   head, head_next;
  logic [OW-1:0] occ;

  fwft_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .wr_en     (DIN_WR_EN),
    .wr_data   (DIN),
    .rd_en     (pop),
    .head      (head),
    .head_next (head_next),
    .occupancy (occ),
    .overflow  (OVERFLOW)
  );

  assign xfer       = valid_q && DOUT_READY;
  assign DOUT       = dout_q;
  assign DOUT_VALID = valid_q;
  assign DOUT_LAST  = last_q;
  assign PKT_CNT    = pkt_cnt_q;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next state and next beat; everything holds unless a beat transfers
  always_comb begin
    state_nxt   = state_q;
    dout_nxt    = dout_q;
    valid_nxt   = valid_q;
    last_nxt    = last_q;
    chk_nxt     = chk_q;
    cnt_nxt     = cnt_q;
    seq_nxt     = seq_q;
    pkt_cnt_nxt = pkt_cnt_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (occ >= PKT_OCC) begin
          state_nxt = HEADER;
          dout_nxt  = {MAGIC, seq_q};
          valid_nxt = 1'b1;
        end
      end
      HEADER: begin
        if (xfer) begin
          state_nxt = PAYLOAD;
          dout_nxt  = head;
          chk_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          pop     = 1'b1;
          chk_nxt = chk_q ^ dout_q;
          cnt_nxt = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            state_nxt = TRAILER;
            dout_nxt  = chk_q ^ dout_q;
            last_nxt  = 1'b1;
          end else begin
            dout_nxt  = head_next;
          end
        end
      end
      TRAILER: begin
        if (xfer) begin
          seq_nxt     = seq_q + 16'd1;
          pkt_cnt_nxt = pkt_cnt_q + 16'd1;
          last_nxt    = 1'b0;
          if (occ >= PKT_OCC) begin
            state_nxt = HEADER;
            dout_nxt  = {MAGIC, seq_q + 16'd1};
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, checksum, payload counter and sequence counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      chk_q     <= '0;
      cnt_q     <= '0;
      seq_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      dout_q    <= dout_nxt;
      valid_q   <= valid_nxt;
      last_q    <= last_nxt;
      chk_q     <= chk_nxt;
      cnt_q     <= cnt_nxt;
      seq_q     <= seq_nxt;
      pkt_cnt_q <= pkt_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_test_data_framer.sv
// Scoreboard bench for test_data_framer (default parameters).
module tb_test_data_framer;

  localparam int PW = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] DIN = '0;
  logic        DIN_WR_EN = 1'b0;
  logic        DOUT_READY = 1'b0;
  logic [31:0] DOUT;
  logic        DOUT_VALID, DOUT_LAST, OVERFLOW;
  logic [15:0] PKT_CNT;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q [$];

  always #5 CLK = ~CLK;

  test_data_framer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .DIN        (DIN),
    .DIN_WR_EN  (DIN_WR_EN),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .DOUT_LAST  (DOUT_LAST),
    .OVERFLOW   (OVERFLOW),
    .PKT_CNT    (PKT_CNT)
  );

  // Monitor: inputs settle 1ns after posedge, so at negedge the values
  // seen are the ones the next posedge will act on.
  initial begin
    logic        stalled;
    logic [32:0] held, e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          total++;
          if (!DOUT_VALID || {DOUT_LAST, DOUT} !== held) begin
            bad++;
            $display("FAIL hold: got valid=%0b last=%0b dout=%h, want valid=1 last=%0b dout=%h",
                     DOUT_VALID, DOUT_LAST, DOUT, held[32], held[31:0]);
          end
        end
        if (DOUT_VALID && DOUT_READY) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat: got unexpected dout=%h last=%0b, want no beat", DOUT, DOUT_LAST);
          end else begin
            e = exp_q.pop_front();
            if ({DOUT_LAST, DOUT} !== e) begin
              bad++;
              $display("FAIL beat: got dout=%h last=%0b, want dout=%h last=%0b",
                       DOUT, DOUT_LAST, e[31:0], e[32]);
            end
          end
          stalled = 1'b0;
        end else if (DOUT_VALID) begin
          stalled = 1'b1;
          held    = {DOUT_LAST, DOUT};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500us");
    $fatal(1);
  end

  // rdy: 0 = low, 1 = high, 2 = random
  task automatic cyc(input logic we, input logic [31:0] d, input int rdy);
    @(posedge CLK);
    #1;
    DIN_WR_EN  = we;
    DIN        = d;
    DOUT_READY = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Header, PW consecutive words from 'first', XOR trailer
  task automatic exp_pkt(input logic [15:0] seq, input logic [31:0] first);
    logic [31:0] x, w;
    x = '0;
    exp_q.push_back({1'b0, 16'hCE9C, seq});
    for (int i = 0; i < PW; i++) begin
      w = first + 32'(i);
      x = x ^ w;
      exp_q.push_back({1'b0, w});
    end
    exp_q.push_back({1'b1, x});
  endtask

  task automatic drain(input int rdy, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      cyc(1'b0, '0, rdy);
      n++;
    end
    repeat (3) cyc(1'b0, '0, 1);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST_N      = 1'b0;
    DIN_WR_EN  = 1'b0;
    DOUT_READY = 1'b0;
    exp_q.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dout",  DOUT, 32'h0);
    chk("rst_valid", 32'(DOUT_VALID), 32'd0);
    chk("rst_last",  32'(DOUT_LAST), 32'd0);
    chk("rst_ovf",   32'(OVERFLOW), 32'd0);
    chk("rst_pkt",   32'(PKT_CNT), 32'd0);
    RST_N = 1'b1;

    // Words 1..100, READY high: 6 packets, 4 words left
    for (int p = 0; p < 6; p++) exp_pkt(16'(p), 32'(PW * p + 1));
    for (int i = 1; i <= 100; i++) cyc(1'b1, 32'(i), 1);
    drain(1, 200);
    chk("t1_pkt",   32'(PKT_CNT), 32'd6);
    chk("t1_ovf",   32'(OVERFLOW), 32'd0);
    chk("t1_left",  32'(dut.u_fifo.occupancy), 32'd4);
    chk("t1_valid", 32'(DOUT_VALID), 32'd0);

    // Same stream with random READY
    do_reset();
    for (int p = 0; p < 6; p++) exp_pkt(16'(p), 32'(PW * p + 1));
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b1, 32'(i), 2);
      cyc(1'b0, '0, 2);
      cyc(1'b0, '0, 2);
    end
    drain(2, 1000);
    chk("t2_pkt",  32'(PKT_CNT), 32'd6);
    chk("t2_ovf",  32'(OVERFLOW), 32'd0);
    chk("t2_left", 32'(dut.u_fifo.occupancy), 32'd4);

    // READY low for 40 words: 8 dropped, then 2 packets of 1..32
    do_reset();
    exp_pkt(16'd0, 32'd1);
    exp_pkt(16'd1, 32'd17);
    for (int i = 1; i <= 40; i++) cyc(1'b1, 32'(i), 0);
    cyc(1'b0, '0, 0);
    chk("t3_ovf",  32'(OVERFLOW), 32'd1);
    chk("t3_full", 32'(dut.u_fifo.occupancy), 32'd32);
    drain(1, 200);
    chk("t3_pkt",  32'(PKT_CNT), 32'd2);
    chk("t3_left", 32'(dut.u_fifo.occupancy), 32'd0);

    // Full FIFO, push and pop together during PAYLOAD: no drop
    do_reset();
    exp_pkt(16'd0, 32'd1);
    exp_pkt(16'd1, 32'd17);
    for (int i = 1; i <= 32; i++) cyc(1'b1, 32'(i), 0);
    cyc(1'b0, '0, 0);
    chk("t4_full", 32'(dut.u_fifo.occupancy), 32'd32);
    cyc(1'b0, '0, 1);
    for (int i = 33; i <= 40; i++) cyc(1'b1, 32'(i), 1);
    cyc(1'b0, '0, 1);
    chk("t4_ovf_mid", 32'(OVERFLOW), 32'd0);
    drain(1, 200);
    chk("t4_ovf",  32'(OVERFLOW), 32'd0);
    chk("t4_pkt",  32'(PKT_CNT), 32'd2);
    chk("t4_left", 32'(dut.u_fifo.occupancy), 32'd8);

    // Reset in the middle of a payload
    do_reset();
    exp_pkt(16'd0, 32'd1);
    for (int i = 1; i <= 16; i++) cyc(1'b1, 32'(i), 1);
    repeat (5) cyc(1'b0, '0, 1);
    chk("t5_busy", 32'(DOUT_VALID), 32'd1);
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_dout",  DOUT, 32'h0);
    chk("t5_valid", 32'(DOUT_VALID), 32'd0);
    chk("t5_last",  32'(DOUT_LAST), 32'd0);
    chk("t5_pkt",   32'(PKT_CNT), 32'd0);
    chk("t5_left",  32'(dut.u_fifo.occupancy), 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    exp_pkt(16'd0, 32'd101);
    for (int i = 101; i <= 116; i++) cyc(1'b1, 32'(i), 1);
    drain(1, 200);
    chk("t5_pkt_after", 32'(PKT_CNT), 32'd1);

    // Sequence and packet count wrap
    do_reset();
    force dut.seq_q = 16'hFFFF;
    force dut.pkt_cnt_q = 16'hFFFF;
    @(posedge CLK);
    #1;
    release dut.seq_q;
    release dut.pkt_cnt_q;
    chk("t6_pkt_pre", 32'(PKT_CNT), 32'h0000FFFF);
    exp_pkt(16'hFFFF, 32'd1);
    exp_pkt(16'h0000, 32'd17);
    for (int i = 1; i <= 32; i++) cyc(1'b1, 32'(i), 1);
    drain(1, 200);
    chk("t6_pkt", 32'(PKT_CNT), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
